// File: rtl/program_loader.sv
// Length-prefixed little-endian byte stream to 32-bit program-memory word writes.
// Optional trailing XOR checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader #(
    parameter int          MEMORY_DEPTH = 32,
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  WriteEnable,
    output logic [31:0]           WriteAddress,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);
    localparam int IW        = $clog2(MEMORY_DEPTH) + 1;
    localparam int NUM_LANES = DATA_WIDTH / 8;

    typedef enum logic [3:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        CHECK,
        DATA,
        WRITE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERROR
    } state_t;

    state_t                         state, state_n;
    logic [15:0]                    len;
    logic [IW-1:0]                  idx;
    logic [1:0]                     bcnt;
    logic [NUM_LANES-1:0][7:0]      word;
    logic                           xfer;
    logic                           last;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]                     csum;
`endif

    assign xfer = ByteValid & ByteReady;
    assign last = ({{(16-IW){1'b0}}, idx} == len - 16'd1);

    always_comb begin
        state_n   = state;
        ByteReady = 1'b0;
        case (state)
            IDLE, DONE, ERROR: if (start) state_n = LEN_LO;
            LEN_LO: begin
                ByteReady = 1'b1;
                if (ByteValid) state_n = LEN_HI;
            end
            LEN_HI: begin
                ByteReady = 1'b1;
                if (ByteValid) state_n = CHECK;
            end
            CHECK: begin
                if (len == 16'd0)                  state_n = DONE;
                else if (int'(len) > MEMORY_DEPTH) state_n = ERROR;
                else                               state_n = DATA;
            end
            DATA: begin
                ByteReady = 1'b1;
                if (ByteValid && bcnt == 2'd3) state_n = WRITE;
            end
            WRITE: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                state_n = last ? CSUM : DATA;
`else
                state_n = last ? DONE : DATA;
`endif
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CSUM: begin
                ByteReady = 1'b1;
                if (ByteValid) state_n = (ByteIn == csum) ? DONE : ERROR;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    assign Busy  = !(state == IDLE || state == DONE || state == ERROR);
    assign Done  = (state == DONE);
    assign Error = (state == ERROR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            len          <= '0;
            idx          <= '0;
            bcnt         <= '0;
            word         <= '0;
            WriteEnable  <= 1'b0;
            WriteAddress <= '0;
            WriteData    <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            state       <= state_n;
            // Strobe is registered off the WRITE state, so it lands the cycle after.
            WriteEnable <= (state == WRITE);
            case (state)
                LEN_LO: if (xfer) len[7:0]  <= ByteIn;
                LEN_HI: if (xfer) len[15:8] <= ByteIn;
                CHECK: begin
                    idx  <= '0;
                    bcnt <= '0;
                end
                DATA: if (xfer) begin
                    word[bcnt] <= ByteIn;
                    bcnt       <= bcnt + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum       <= csum ^ ByteIn;
`endif
                end
                WRITE: begin
                    WriteAddress <= BASE_ADDRESS + {{(30-IW){1'b0}}, idx, 2'b00};
                    WriteData    <= word;
                    idx          <= idx + 1'b1;
                end
                default: ;
            endcase
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (state_n == LEN_LO && state != LEN_LO) csum <= '0;
`endif
        end
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream writer that fills the instruction memory before the core runs: receives a length-prefixed little-endian byte stream, assembles 32-bit words, and issues single-cycle word writes to the program memory's write port.
- Sits between the host byte link (UART receiver or bench) and the program RAM.
- Write addresses are byte addresses, word-aligned, starting at BASE_ADDRESS, matching the core's fetch addressing.

Parameters:
- MEMORY_DEPTH, 32, number of words in program memory; the maximum accepted load length.
- DATA_WIDTH, 32, word width; fixed at 32 (4 bytes per word).
- BASE_ADDRESS, 32'h0040_0000, byte address of the first word written.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a load; sampled in IDLE, DONE or ERROR only.
- ByteIn  input  8  stream byte.
- ByteValid  input  1  ByteIn valid.
- ByteReady  output  1  loader can accept; a byte transfers on a rising edge with ByteValid & ByteReady.
- WriteEnable  output  1  one-cycle word write strobe.
- WriteAddress  output  32  byte address of the write.
- WriteData  output  32  assembled word.
- Busy  output  1  load in progress.
- Done  output  1  load completed successfully; level.
- Error  output  1  load aborted; level.

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0; word index, byte counter, length, shift register and checksum cleared. Any partial word is discarded and no write is issued.
- Registered outputs: WriteAddress and WriteData hold their last value between writes.
- States: IDLE, LEN_LO, LEN_HI, CHECK, DATA, WRITE, CSUM (macro only), DONE, ERROR.
- IDLE/DONE/ERROR + start=1 -> LEN_LO; Done and Error cleared on that edge. start is ignored in all other states.
- LEN_LO: ByteReady=1; accepted byte becomes N[7:0] -> LEN_HI.
- LEN_HI: ByteReady=1; accepted byte becomes N[15:8] -> CHECK.
- CHECK, one cycle, ByteReady=0:
  - N==0 -> DONE.
  - N>MEMORY_DEPTH -> ERROR.
  - Otherwise -> DATA with index=0 and byte count=0.
- DATA: ByteReady=1. Each accepted byte fills lane byte count (lane 0 = bits 7:0, little-endian). After the 4th byte -> WRITE. Cycles without ByteValid do not advance.
- WRITE, exactly one cycle, ByteReady=0:
  - WriteEnable=1, WriteData=assembled word, WriteAddress=BASE_ADDRESS+{index,2'b00}, all registered.
  - If index==N-1 -> CSUM when the macro is enabled, else DONE.
  - Otherwise index+1 -> DATA.
- Write spacing: at most one write per 5 cycles at full byte rate. First WriteEnable is asserted 2 cycles after the 4th data byte's accepting edge.
- Busy=1 in LEN_LO..CSUM; 0 in IDLE, DONE, ERROR.
- Widths: N is 16 bits; index is clog2(MEMORY_DEPTH)+1 bits. Address arithmetic is 32-bit modulo 2^32.
- ERROR: no further writes; words already written remain in memory.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Enabled:
  - An 8-bit running XOR of all 4N payload bytes (length bytes excluded) is cleared on entry to LEN_LO.
  - After the last WRITE, the loader enters CSUM with ByteReady=1 and accepts one byte.
  - Byte equals the XOR -> DONE; mismatch -> ERROR.
  - For N==0, CHECK goes directly to DONE with no checksum byte.
- Disabled: the CSUM state and XOR register are absent; the last WRITE goes to DONE.

Test Plan:
- start; bytes 02 00 78 56 34 12 EF BE AD DE -> WriteEnable pulses: (0x00400000, 0x12345678), then (0x00400004, 0xDEADBEEF); Done=1, Busy=0. With the macro, append 2A -> Done=1.
- start; bytes 00 00 -> no WriteEnable; Done=1 two cycles after the second byte is accepted; Error=0.
- start; bytes 21 00 (N=33 > 32) -> Error=1, no write, ByteReady=0. Then start -> Error=0, LEN_LO.
- Same stream as the first scenario with ByteValid low for 3 cycles between every byte -> identical writes; WriteEnable never wider than 1 cycle; ByteReady=0 during WRITE.
- start; bytes 01 00 78 56, then reset=0 -> all outputs 0 immediately, no write. Release reset; start; 01 00 11 22 33 44 -> one write (0x00400000, 0x44332211).
- Macro on: 01 00 78 56 34 12 08 -> Done=1. Same stream with 09 -> Error=1, and the word at 0x00400000 has already been written.
